axi_skiroc_sc_regs: RTL and testbench

AXI_SKIROC_SC_REGS -- requirements
Module: axi_skiroc_sc_regs

---
 rtl/axi_skiroc_sc_regs_if.sv | 52 +++++
 rtl/axi_skiroc_sc_regs.sv | 147 ++++++++++++++
 tb/tb_axi_skiroc_sc_regs.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_skiroc_sc_regs_if.sv
// AXI4-Lite bus bundle for the SKIROC slow-control register slave.
// The master drives the request side and the slave drives the ready/response side.
interface axi_skiroc_sc_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_skiroc_sc_regs.sv
// Four 32-bit AXI4-Lite slow-control registers for the SKIROC front end,
// with byte-strobed writes, a per-register write strobe and independent read/write FSMs.
module axi_skiroc_sc_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_skiroc_sc_regs_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sc_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sc_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sc_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sc_reg3,
  output logic [3:0]                    sc_wr_pulse
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t                        w_state_r;
  r_state_t                        r_state_r;
  logic                            bvalid_r;
  logic                            rvalid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_r;
  logic [3:0]                      wr_pulse_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   regs_r [0:3];
  logic                            wr_hs_s;
  logic                            rd_hs_s;
  logic [1:0]                      awsel_s;
  logic [1:0]                      arsel_s;
  logic                            unused_s;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
    input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]             strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Ready is combinational so AW/W are accepted in the very cycle both valids are seen;
  // gating with reset keeps it low while reset is held.
  assign awsel_s = s_axi.S_AXI_AWADDR[3:2];
  assign arsel_s = s_axi.S_AXI_ARADDR[3:2];
  assign wr_hs_s = S_AXI_ARESETN && (w_state_r == W_IDLE) && !bvalid_r &&
                   s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign rd_hs_s = S_AXI_ARESETN && (r_state_r == R_IDLE) && !rvalid_r &&
                   s_axi.S_AXI_ARVALID;

  assign s_axi.S_AXI_AWREADY = wr_hs_s;
  assign s_axi.S_AXI_WREADY  = wr_hs_s;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = rd_hs_s;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign sc_reg0     = regs_r[0];
  assign sc_reg1     = regs_r[1];
  assign sc_reg2     = regs_r[2];
  assign sc_reg3     = regs_r[3];
  assign sc_wr_pulse = wr_pulse_r;

  assign unused_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Write FSM: accept AW+W together, then hold the response until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_r  <= W_IDLE;
      bvalid_r   <= 1'b0;
      wr_pulse_r <= 4'b0000;
    end else begin
      wr_pulse_r <= 4'b0000;
      case (w_state_r)
        W_IDLE: begin
          if (wr_hs_s) begin
            w_state_r  <= W_RESP;
            bvalid_r   <= 1'b1;
            wr_pulse_r <= 4'b0001 << awsel_s;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Register file: byte-strobed update on the write handshake edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= {C_S_AXI_DATA_WIDTH{1'b0}};
      end
    end else if (wr_hs_s) begin
      regs_r[awsel_s] <= merge_bytes(regs_r[awsel_s], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
    end
  end

  // Read FSM: data sampled from the pre-write register value on the AR handshake edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_r <= R_IDLE;
      rvalid_r  <= 1'b0;
      rdata_r   <= {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (rd_hs_s) begin
            r_state_r <= R_DATA;
            rvalid_r  <= 1'b1;
            rdata_r   <= regs_r[arsel_s];
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_skiroc_sc_regs.sv
// Directed bench for axi_skiroc_sc_regs: a vector table of strobed writes with
// readback, plus hand-written stall, concurrency and reset sequences.
module tb_axi_skiroc_sc_regs;
  logic        tb_ACLK;
  logic        tb_ARESETN;
  logic [31:0] sc_reg0, sc_reg1, sc_reg2, sc_reg3;
  logic [3:0]  sc_wr_pulse;
  int          checks;
  int          failures;

  axi_skiroc_sc_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_skiroc_sc_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (tb_ARESETN),
    .s_axi         (bus),
    .sc_reg0       (sc_reg0),
    .sc_reg1       (sc_reg1),
    .sc_reg2       (sc_reg2),
    .sc_reg3       (sc_reg3),
    .sc_wr_pulse   (sc_wr_pulse)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sc_reg_of(input int n);
    case (n)
      0: return sc_reg0;
      1: return sc_reg1;
      2: return sc_reg2;
      default: return sc_reg3;
    endcase
  endfunction

  task automatic idle_bus();
    bus.S_AXI_AWADDR  = 4'h0; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = 32'h0; bus.S_AXI_WSTRB = 4'h0;   bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = 4'h0; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
  endtask

  // Called at a negedge; returns at a later negedge with the bus idle.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [3:0] pulse);
    int n;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    #1;
    n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 16) begin
      @(negedge tb_ACLK); #1; n++;
    end
    check("wr_ready", {31'b0, bus.S_AXI_AWREADY && bus.S_AXI_WREADY}, 32'd1);
    @(negedge tb_ACLK);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    pulse = sc_wr_pulse;
    check("bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
    check("bresp", {30'b0, bus.S_AXI_BRESP}, 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge tb_ACLK);
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_clr", {31'b0, bus.S_AXI_BVALID}, 32'd0);
    check("pulse_clr", {28'b0, sc_wr_pulse}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 16) begin
      @(negedge tb_ACLK); #1; n++;
    end
    check("arready", {31'b0, bus.S_AXI_ARREADY}, 32'd1);
    @(negedge tb_ACLK);
    bus.S_AXI_ARVALID = 1'b0;
    check("rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
    check("rresp", {30'b0, bus.S_AXI_RRESP}, 32'd0);
    data = bus.S_AXI_RDATA;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge tb_ACLK);
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_clr", {31'b0, bus.S_AXI_RVALID}, 32'd0);
  endtask

  initial begin
    logic [3:0]  pulse;
    logic [31:0] rd;
    logic [31:0] exp_regs [0:3];
    checks = 0;
    failures = 0;

    vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF, 4'b0001};
    vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 32'hABCD0001, 4'b0010};
    vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 32'hDEAD0011, 4'b0100};
    vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 32'hBEEF0011, 4'b1000};
    vecs[4] = '{4'h4, 32'h11223344, 4'b0101, 32'hAB220044, 4'b0010};
    vecs[5] = '{4'hE, 32'h12345678, 4'b0000, 32'hBEEF0011, 4'b1000};
    vecs[6] = '{4'h3, 32'hAA000000, 4'b1000, 32'hAA01FFFF, 4'b0001};

    // Reset with requests pending: nothing may be accepted.
    idle_bus();
    tb_ARESETN = 1'b0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    #1;
    check("rst_ready", {29'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd0);
    check("rst_valid", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    check("rst_regs", sc_reg0 | sc_reg1 | sc_reg2 | sc_reg3, 32'd0);
    check("rst_pulse", {28'b0, sc_wr_pulse}, 32'd0);
    idle_bus();
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);

    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, pulse);
      check($sformatf("pulse_v%0d", i), {28'b0, pulse}, {28'b0, vecs[i].exp_pulse});
      check($sformatf("screg_v%0d", i), sc_reg_of(int'(vecs[i].addr[3:2])), vecs[i].exp);
      axi_read(vecs[i].addr, rd);
      check($sformatf("rdata_v%0d", i), rd, vecs[i].exp);
    end
    exp_regs[0] = 32'hAA01FFFF; exp_regs[1] = 32'hAB220044;
    exp_regs[2] = 32'hDEAD0011; exp_regs[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("screg_all%0d", i), sc_reg_of(i), exp_regs[i]);
    end

    // AW three cycles ahead of W, then a long BREADY stall with a second request waiting.
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'h11111111; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("aw_only_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd0);
      @(negedge tb_ACLK);
    end
    bus.S_AXI_WVALID = 1'b1;
    #1;
    check("aw_w_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd3);
    @(negedge tb_ACLK);
    bus.S_AXI_WDATA = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      check("stall_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd0);
      @(negedge tb_ACLK);
    end
    check("stall_reg0", sc_reg0, 32'h11111111);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge tb_ACLK);
    bus.S_AXI_BREADY = 1'b0;
    #1;
    check("second_bvalid_low", {31'b0, bus.S_AXI_BVALID}, 32'd0);
    check("second_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd3);
    @(negedge tb_ACLK);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge tb_ACLK);
    bus.S_AXI_BREADY = 1'b0;
    axi_read(4'h0, rd);
    check("second_rdata", rd, 32'h22222222);

    // W ahead of AW.
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'h0;
    bus.S_AXI_WVALID = 1'b1;
    #1;
    check("w_only_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd0);
    @(negedge tb_ACLK);
    bus.S_AXI_WVALID = 1'b0;

    // Same-edge read and write of reg2: read returns the old contents.
    bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_WDATA = 32'h00000005; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 4'h8; bus.S_AXI_ARVALID = 1'b1;
    #1;
    check("conc_ready", {29'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd7);
    @(negedge tb_ACLK);
    idle_bus();
    check("conc_rdata", bus.S_AXI_RDATA, 32'hDEAD0011);
    check("conc_valids", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd3);
    check("conc_reg2", sc_reg2, 32'h00000005);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(negedge tb_ACLK);
    idle_bus();
    axi_read(4'h8, rd);
    check("conc_later", rd, 32'h00000005);

    // Reset while RVALID is stalled and a lone AW is pending.
    bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
    @(negedge tb_ACLK);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'hFFFFFFFF; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    check("pre_rst_rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
    #1;
    tb_ARESETN = 1'b0;
    #1;
    check("async_rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd0);
    check("async_rdata", bus.S_AXI_RDATA, 32'd0);
    check("async_regs", sc_reg0 | sc_reg1 | sc_reg2 | sc_reg3, 32'd0);
    repeat (2) @(negedge tb_ACLK);
    idle_bus();
    tb_ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge tb_ACLK);
      check("post_rst_valids", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check($sformatf("post_rst_rd%0d", i), rd, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
